// File: rtl/psc_trigger_frame_tx_if.sv
// Byte-stream and frame-ROM signals between the trigger frame transmitter,
// its frame data ROM and the downstream link encoder.
interface psc_trigger_frame_tx_if;
    logic [7:0] tx_data;
    logic       tx_k;
    logic       tx_valid;
    logic       tx_ready;
    logic [3:0] rom_address;
    logic       rom_is_trigger;
    logic [7:0] rom_data;

    modport master (
        output tx_data, tx_k, tx_valid, rom_address, rom_is_trigger,
        input  tx_ready, rom_data
    );

    modport slave (
        input  tx_data, tx_k, tx_valid, rom_address, rom_is_trigger,
        output tx_ready, rom_data
    );
endinterface

// File: rtl/psc_trigger_frame_tx.sv
// Sends 11-byte trigger or heartbeat frames read from an external ROM as a
// registered K/data byte stream, with idle characters between frames.
module psc_trigger_frame_tx #(
    parameter int unsigned HB_PERIOD = 1000,
    parameter int unsigned MIN_GAP   = 2,
    parameter logic [7:0]  IDLE_CHAR = 8'hBC
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      trigger_in,
    psc_trigger_frame_tx_if.master    link,
    output logic                      busy,
    output logic [15:0]               trig_frame_count,
    output logic [7:0]                drop_count
);

    localparam logic [3:0] LAST_ADDR = 4'd10;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t      state, state_next;
    logic [3:0]  byte_idx, byte_idx_next;
    logic [3:0]  gap_cnt, gap_cnt_next;
    logic        frame_trig, frame_trig_next;
    logic        trig_pending, hb_pending;
    logic [15:0] hb_cnt;
    logic        hb_tc;
    logic        load_en;
    logic        start_trig, start_hb, eop_accept;
    logic [7:0]  tx_data_next;
    logic        tx_k_next;

    assign hb_tc   = (hb_cnt == 16'(HB_PERIOD - 1));
    assign load_en = !link.tx_valid || link.tx_ready;
    assign busy    = (state == SEND);

    // In IDLE the ROM is pre-addressed with the type of the frame that would
    // start next, so the SOP byte is loaded on the very edge that enters SEND.
    always_comb begin
        link.rom_address    = 4'd0;
        link.rom_is_trigger = trig_pending;
        if (state == SEND) begin
            link.rom_address    = (byte_idx == LAST_ADDR) ? LAST_ADDR : byte_idx + 4'd1;
            link.rom_is_trigger = frame_trig;
        end else if (state == GAP) begin
            link.rom_is_trigger = frame_trig;
        end
    end

    always_comb begin
        state_next      = state;
        byte_idx_next   = byte_idx;
        gap_cnt_next    = gap_cnt;
        frame_trig_next = frame_trig;
        tx_data_next    = IDLE_CHAR;
        tx_k_next       = 1'b1;
        start_trig      = 1'b0;
        start_hb        = 1'b0;
        eop_accept      = 1'b0;
        unique case (state)
            IDLE: begin
                if (load_en && (trig_pending || hb_pending)) begin
                    state_next      = SEND;
                    frame_trig_next = trig_pending;
                    start_trig      = trig_pending;
                    start_hb        = !trig_pending;
                    byte_idx_next   = 4'd0;
                    tx_data_next    = link.rom_data;
                end
            end
            SEND: begin
                if (load_en) begin
                    if (byte_idx == LAST_ADDR) begin
                        state_next    = GAP;
                        eop_accept    = 1'b1;
                        byte_idx_next = 4'd0;
                        gap_cnt_next  = 4'd0;
                    end else begin
                        byte_idx_next = byte_idx + 4'd1;
                        tx_data_next  = link.rom_data;
                        tx_k_next     = (byte_idx == 4'd8) || (byte_idx == 4'd9);
                    end
                end
            end
            GAP: begin
                if (load_en) begin
                    gap_cnt_next = gap_cnt + 4'd1;
                    if (gap_cnt_next == 4'(MIN_GAP)) begin
                        state_next   = IDLE;
                        gap_cnt_next = 4'd0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            byte_idx   <= 4'd0;
            gap_cnt    <= 4'd0;
            frame_trig <= 1'b0;
        end else begin
            state      <= state_next;
            byte_idx   <= byte_idx_next;
            gap_cnt    <= gap_cnt_next;
            frame_trig <= frame_trig_next;
        end
    end

    // A trigger on the consume cycle re-arms the flag instead of being dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            link.tx_valid    <= 1'b0;
            link.tx_data     <= 8'h00;
            link.tx_k        <= 1'b0;
            trig_pending     <= 1'b0;
            hb_pending       <= 1'b0;
            hb_cnt           <= 16'd0;
            trig_frame_count <= 16'd0;
            drop_count       <= 8'd0;
        end else begin
            link.tx_valid <= 1'b1;
            if (load_en) begin
                link.tx_data <= tx_data_next;
                link.tx_k    <= tx_k_next;
            end
            trig_pending <= trigger_in || (trig_pending && !start_trig);
            hb_pending   <= hb_tc || (hb_pending && !start_hb);
            hb_cnt       <= hb_tc ? 16'd0 : hb_cnt + 16'd1;
            if (trigger_in && trig_pending && !start_trig && drop_count != 8'hFF) begin
                drop_count <= drop_count + 8'd1;
            end
            if (eop_accept && frame_trig) begin
                trig_frame_count <= trig_frame_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_psc_trigger_frame_tx.sv
// Randomized bench for psc_trigger_frame_tx against a character-queue model
// of the frame/idle stream and the trigger/heartbeat request rules.
module tb_psc_trigger_frame_tx;

    localparam int         HB        = 16;
    localparam int         MG        = 2;
    localparam logic [7:0] IDLE_CHAR = 8'hBC;

    typedef struct packed {
        logic       k;
        logic [7:0] d;
    } chr_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        trigger_in = 1'b0;
    logic        tx_ready_drv = 1'b1;
    logic        busy;
    logic [15:0] trig_frame_count;
    logic [7:0]  drop_count;
    logic [7:0]  rom [2][16];

    int assert_count = 0;
    int fail_count   = 0;

    chr_t out_q[$];
    bit   m_valid;
    int   frame_left;
    int   gap_left;
    bit   m_trig_pend;
    bit   m_hb_pend;
    int   hb_timer;
    bit   cur_trig;
    int   m_tfc;
    int   m_drop;

    psc_trigger_frame_tx_if bus();

    assign bus.tx_ready = tx_ready_drv;
    assign bus.rom_data = rom[bus.rom_is_trigger][bus.rom_address];

    psc_trigger_frame_tx #(
        .HB_PERIOD (HB),
        .MIN_GAP   (MG),
        .IDLE_CHAR (IDLE_CHAR)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .trigger_in       (trigger_in),
        .link             (bus),
        .busy             (busy),
        .trig_frame_count (trig_frame_count),
        .drop_count       (drop_count)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        if (observed !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Frame ROM: spec frame content, optionally with random payload bytes.
    task automatic loadRom(input bit random_payload);
        for (int t = 0; t < 2; t++) begin
            for (int a = 0; a < 16; a++) rom[t][a] = (a <= 10) ? 8'h00 : 8'hEE;
            rom[t][0]  = 8'h3C;
            rom[t][9]  = 8'hBC;
            rom[t][10] = 8'hBC;
        end
        rom[1][1] = 8'h01;
        rom[1][2] = 8'h30;
        if (random_payload) begin
            for (int t = 0; t < 2; t++)
                for (int a = 1; a <= 8; a++) rom[t][a] = 8'($urandom);
        end
    endtask

    task automatic modelReset();
        out_q.delete();
        m_valid     = 1'b0;
        frame_left  = 0;
        gap_left    = 0;
        m_trig_pend = 1'b0;
        m_hb_pend   = 1'b0;
        hb_timer    = 0;
        cur_trig    = 1'b0;
        m_tfc       = 0;
        m_drop      = 0;
    endtask

    task automatic modelStep(input bit trig, input bit rdy);
        bit   accepted, load, eligible, start_t, start_h, tc;
        chr_t c;
        accepted = m_valid && rdy;
        load     = !m_valid || rdy;
        eligible = (frame_left == 0) && (gap_left == 0);
        start_t  = 1'b0;
        start_h  = 1'b0;
        if (accepted) begin
            out_q.delete(0);
            if (frame_left > 0) begin
                frame_left--;
                if (frame_left == 0) begin
                    gap_left = MG;
                    if (cur_trig) m_tfc = (m_tfc + 1) % 65536;
                end
            end else if (gap_left > 0) begin
                gap_left--;
            end
        end
        if (load && out_q.size() == 0) begin
            if (eligible && (m_trig_pend || m_hb_pend)) begin
                cur_trig = m_trig_pend;
                start_t  = m_trig_pend;
                start_h  = !m_trig_pend;
                for (int i = 0; i < 11; i++) begin
                    c.k = (i == 0) || (i >= 9);
                    c.d = rom[cur_trig][i];
                    out_q.push_back(c);
                end
                frame_left = 11;
            end else begin
                c.k = 1'b1;
                c.d = IDLE_CHAR;
                out_q.push_back(c);
            end
        end
        m_valid = 1'b1;
        hb_timer++;
        tc = (hb_timer == HB);
        if (tc) hb_timer = 0;
        if (trig && m_trig_pend && !start_t && m_drop < 255) m_drop++;
        m_trig_pend = (m_trig_pend && !start_t) || trig;
        m_hb_pend   = (m_hb_pend && !start_h) || tc;
    endtask

    task automatic compareAll();
        checkOutput("tx_valid", bus.tx_valid, m_valid);
        if (m_valid) begin
            checkOutput("tx_data", bus.tx_data, out_q[0].d);
            checkOutput("tx_k", bus.tx_k, out_q[0].k);
        end else begin
            checkOutput("tx_data_reset", bus.tx_data, 8'h00);
            checkOutput("tx_k_reset", bus.tx_k, 1'b0);
        end
        checkOutput("busy", busy, frame_left > 0);
        checkOutput("trig_frame_count", trig_frame_count, m_tfc);
        checkOutput("drop_count", drop_count, m_drop);
        checkOutput("rom_address_range", bus.rom_address <= 4'd10, 1'b1);
        if (frame_left > 0) checkOutput("rom_is_trigger", bus.rom_is_trigger, cur_trig);
        else checkOutput("rom_address_idle", bus.rom_address, 4'd0);
    endtask

    task automatic applyStimulus(input bit trig, input bit rdy);
        trigger_in   = trig;
        tx_ready_drv = rdy;
        @(posedge clk);
        modelStep(trig, rdy);
        @(negedge clk);
        compareAll();
    endtask

    // Asserts reset away from the clock edge and checks outputs at once.
    task automatic doReset(input bit random_payload);
        trigger_in = 1'b0;
        reset_n    = 1'b0;
        #1;
        loadRom(random_payload);
        modelReset();
        compareAll();
        checkOutput("reset_rom_is_trigger", bus.rom_is_trigger, 1'b0);
        @(negedge clk);
        compareAll();
        reset_n = 1'b1;
    endtask

    task automatic waitFrameLeft(input int target, input string tag);
        for (int i = 0; i < 60 && frame_left != target; i++) applyStimulus(1'b0, 1'b1);
        if (frame_left != target) checkOutput(tag, frame_left, target);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        loadRom(1'b0);
        modelReset();
        @(negedge clk);

        // Single trigger with spec ROM content, then heartbeats only.
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 30; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("single_trigger_count", trig_frame_count, 16'd1);

        doReset(1'b0);
        for (int i = 0; i < 60; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("heartbeat_only_count", trig_frame_count, 16'd0);

        // Back-pressure during a frame.
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1);
        for (int i = 0; i < 80; i++) applyStimulus(1'b0, 1'($urandom_range(1, 0)));

        // Three triggers inside one frame: one queued, two dropped.
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1);
        waitFrameLeft(10, "timeout_frame_start");
        for (int i = 0; i < 5; i++) applyStimulus(i % 2 == 0, 1'b1);
        checkOutput("burst_drop_count", drop_count, 8'd2);
        for (int i = 0; i < 40; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("burst_frame_count", trig_frame_count, 16'd2);

        // Trigger coinciding with heartbeat terminal count while idle.
        doReset(1'b0);
        for (int i = 0; i < 100 && hb_timer != HB - 1; i++) applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("coincide_first_is_trigger", bus.rom_is_trigger, 1'b1);
        for (int i = 0; i < 12; i++) applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 30 && frame_left == 0; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("coincide_second_is_heartbeat", bus.rom_is_trigger, 1'b0);
        checkOutput("coincide_frame_count", trig_frame_count, 16'd1);

        // Reset while byte 5 of a trigger frame is presented.
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1);
        waitFrameLeft(6, "timeout_byte5");
        doReset(1'b0);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        checkOutput("after_abort_sop", bus.tx_data, 8'h3C);
        for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1);
        checkOutput("after_abort_count", trig_frame_count, 16'd1);

        // Random traffic with random payloads, then a trigger storm.
        doReset(1'b1);
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(5, 0) == 0, $urandom_range(3, 0) != 0);
        doReset(1'b1);
        for (int i = 0; i < 1500; i++)
            applyStimulus(1'($urandom_range(1, 0)), $urandom_range(7, 0) != 0);
        checkOutput("drop_saturated", drop_count, 8'hFF);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule

// File: doc/psc_trigger_frame_tx.md
PSC_TRIGGER_FRAME_TX -- requirements
Module: psc_trigger_frame_tx

Interface
REQ-001 The block SHALL have parameter HB_PERIOD, default 1000: cycles between heartbeat (non-trigger) frame requests; legal range 16..65535.
REQ-002 The block SHALL have parameter MIN_GAP, default 2: minimum idle characters sent between EOP and the next SOP; legal range 1..15.
REQ-003 The block SHALL have parameter IDLE_CHAR, default 8'hBC: idle character, sent with tx_k=1.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port trigger_in, input, 1 bit: trigger request, sampled each cycle; each high cycle is one request.
REQ-007 The block SHALL have port rom_address, output, 4 bits: frame byte index driven to the frame data ROM.
REQ-008 The block SHALL have port rom_is_trigger, output, 1 bit: frame type selector to the ROM; 1 = trigger frame, 0 = heartbeat frame.
REQ-009 The block SHALL have port rom_data, input, 8 bits: combinational ROM response for rom_address/rom_is_trigger.
REQ-010 The block SHALL have ports tx_data (output, 8 bits), tx_k (output, 1 bit) and tx_valid (output, 1 bit): the registered byte stream to the link encoder; tx_k=1 marks a control character.
REQ-011 The block SHALL have port tx_ready, input, 1 bit: link encoder accepts the byte when tx_valid&tx_ready.
REQ-012 The block SHALL have port busy, output, 1 bit: high from frame start until EOP is accepted.
REQ-013 The block SHALL have port trig_frame_count, output, 16 bits: number of completed trigger frames; wraps modulo 2^16.
REQ-014 The block SHALL have port drop_count, output, 8 bits: number of trigger requests lost; saturates at 255.

Function
REQ-015 The block SHALL implement states IDLE, SEND and GAP.
REQ-016 A frame SHALL consist of ROM addresses 0..10 in order, 11 bytes, with SOP at address 0 and EOP at addresses 9 and 10.
REQ-017 tx_k SHALL be 1 for bytes from addresses 0, 9 and 10, and for idle characters; it SHALL be 0 otherwise.
REQ-018 In IDLE and GAP, tx_valid SHALL be 1, tx_data SHALL be IDLE_CHAR and tx_k SHALL be 1; each accepted idle character counts toward MIN_GAP.
REQ-019 The block SHALL have a one-entry trigger pending flag that is set by trigger_in.
REQ-020 If trigger_in is high while the pending flag is already set, and the flag is not being consumed that cycle, drop_count SHALL increment.
REQ-021 A trigger_in arriving while a frame is in SEND SHALL set the pending flag if it is clear; otherwise it SHALL count as dropped.
REQ-022 The heartbeat counter SHALL count every cycle and reach terminal count after HB_PERIOD cycles.
REQ-023 At heartbeat terminal count the block SHALL set a heartbeat-pending flag, and the counter SHALL restart from 0.
REQ-024 IDLE->SEND SHALL occur when any request is pending; trigger SHALL have priority over heartbeat.
REQ-025 On IDLE->SEND, rom_is_trigger SHALL be set to the frame type and held constant until the frame ends; the consumed pending flag SHALL be cleared.
REQ-026 A simultaneous new trigger_in on the consume cycle SHALL re-set the pending flag and SHALL NOT count as dropped.
REQ-027 A heartbeat pending when a trigger frame starts SHALL remain pending.
REQ-028 The SOP byte SHALL appear on tx_data, with tx_valid=1, in the cycle after the IDLE->SEND edge.
REQ-029 With tx_ready held high, bytes SHALL be presented back-to-back, one per cycle, so the frame occupies 11 consecutive cycles.
REQ-030 While tx_valid=1 and tx_ready=0, tx_data and tx_k SHALL hold stable, and rom_address SHALL NOT advance.
REQ-031 Acceptance of the address-10 byte SHALL cause the transition SEND->GAP, clear busy, and increment trig_frame_count if rom_is_trigger=1.
REQ-032 GAP->IDLE SHALL occur after MIN_GAP idle characters are accepted; a request pending at that point SHALL start immediately on the next cycle.
REQ-033 rom_address SHALL be 0 in IDLE and GAP, and SHALL never exceed 10.

Reset
REQ-034 While reset_n=0 the block SHALL set: state IDLE, tx_valid=0, tx_data=8'h00, tx_k=0, rom_address=0, rom_is_trigger=0, busy=0, both counters 0, both pending flags 0, heartbeat counter 0.
REQ-035 tx_valid SHALL rise on the first clock edge after reset_n deasserts.
REQ-036 Reset asserted mid-frame SHALL abort the frame immediately; no EOP is sent, and no counter is incremented for the aborted frame.

Verification
REQ-037 Scenario: reset release, tx_ready=1, single trigger_in pulse -> bytes 3C,01,30,00,00,00,00,00,00,BC,BC with k=1,0,0,0,0,0,0,0,0,1,1, then at least 2 BC idles; trig_frame_count=1.
REQ-038 Scenario: no triggers, HB_PERIOD=16 -> heartbeat frame 3C,00,00,...,BC,BC every 16 cycles; trig_frame_count stays 0.
REQ-039 Scenario: tx_ready toggled 1,0,0,1 pseudo-randomly during a frame -> no byte lost or duplicated; data stable during stall cycles.
REQ-040 Scenario: 3 trigger pulses during one frame -> exactly one further trigger frame follows; drop_count=2.
REQ-041 Scenario: trigger and heartbeat terminal count in the same cycle while IDLE -> trigger frame first, then heartbeat frame after MIN_GAP idles.
REQ-042 Scenario: reset_n pulsed low at byte 5 of a frame -> outputs at reset values immediately; the next frame after release starts with 3C.
